// File: rtl/fp_mul_arb_pkg.sv
// Shared types and helpers for the fp_mul_arbiter slice: FSM states, FP word width
// and the round-robin pick function (up to RR_MAX requesters).
package fp_mul_arb_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned RR_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], searching upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [2:0]        ptr,
                                       input int unsigned       n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      j = (32'(ptr) + k) % n;
      if (k < n && !r.found && valid[3'(j)]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ieee754_multiplier.sv
// Combinational IEEE754 single-precision multiply, round-to-nearest-even.
// Subnormal inputs/results flush to signed zero; any NaN result is 32'h7fc00000.
module ieee754_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        sa, sb, s;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [47:0] p;
  logic [10:0] e;
  logic [22:0] m;
  logic        g, st;
  logic [23:0] mr;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    fa = a[22:0];
    fb = b[22:0];
    s  = sa ^ sb;

    a_nan  = (ea == 8'hff) && (fa != '0);
    b_nan  = (eb == 8'hff) && (fb != '0);
    a_inf  = (ea == 8'hff) && (fa == '0);
    b_inf  = (eb == 8'hff) && (fb == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);

    p = {24'h0, 1'b1, fa} * {24'h0, 1'b1, fb};
    e = 11'(ea) + 11'(eb) - 11'd127;

    // Product of two [1,2) significands lies in [1,4): normalise by at most one place.
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 11'd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end

    mr = {1'b0, m} + 24'((g && (st || m[0])) ? 1 : 0);
    if (mr[23]) e = e + 11'd1;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      y = 32'h7fc00000;
    else if (a_inf || b_inf)
      y = {s, 8'hff, 23'h0};
    else if (a_zero || b_zero)
      y = {s, 31'h0};
    else if (e[10] || e == 11'd0)
      y = {s, 31'h0};
    else if (e >= 11'd255)
      y = {s, 8'hff, 23'h0};
    else
      y = {s, e[7:0], mr[22:0]};
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one ieee754_multiplier among NREQ requesters.
// Define FP_MUL_ARB_STATS_EN to build the op_count handshake counter (else tied to 0).
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [FP_W-1:0]      rsp_result,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          op_count
);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id;
  logic [ID_W-1:0]     gidx;
  logic [FP_W-1:0]     op_a, op_b, prod;
  logic [RR_MAX-1:0]   vld;
  rr_pick_t            pick;

  always_comb begin
    vld            = '0;
    vld[NREQ-1:0]  = req_valid;
    pick           = rr_pick(vld, 3'(rr_ptr), NREQ);
    gidx           = ID_W'(pick.idx);
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && pick.found)
      req_ready[gidx] = 1'b1;
  end

  ieee754_multiplier u_mul (
    .a (op_a),
    .b (op_b),
    .y (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.found) begin
            op_a   <= req_a[FP_W*gidx +: FP_W];
            op_b   <= req_b[FP_W*gidx +: FP_W];
            id     <= gidx;
            rr_ptr <= (gidx == ID_W'(NREQ-1)) ? '0 : gidx + ID_W'(1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= prod;
          rsp_id     <= id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_MUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      op_count <= '0;
    else if (rsp_valid && rsp_ready)
      op_count <= op_count + 32'd1;
  end
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed vectors push expected (id, result);
// a negedge monitor pops and compares on every response handshake.
module tb_fp_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       op_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_res[$];
  int          exp_id[$];
  logic [NREQ-1:0] hs;

  fp_mul_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event @%0t", name, $time);
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_res.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=id%0d/%h required=none @%0t", rsp_id, rsp_result, $time);
      end else begin
        check("rsp_result", rsp_result, exp_res.pop_front());
        check("rsp_id", 32'(rsp_id), 32'(exp_id.pop_front()));
      end
    end
  end

  // Requesters drop req_valid right after the edge on which they were accepted.
  always @(negedge clk) hs = req_valid & req_ready;
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~hs;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] res);
    exp_id.push_back(id);
    exp_res.push_back(res);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_drop(input int i);
    bit done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      tick();
      if (!req_valid[i]) done = 1;
    end
    if (!done) fail_now("grant_wait");
  endtask

  task automatic wait_drain(input int maxcyc);
    bit done = 0;
    for (int k = 0; k < maxcyc && !done; k++) begin
      @(negedge clk);
      if (exp_res.size() == 0 && !rsp_valid && req_valid == '0) done = 1;
    end
    if (!done) fail_now("drain_wait");
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    req_valid = '1;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_op_count", op_count, 32'd0);
    tick();
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // Single request: same-cycle ready, response two edges later.
    expect_rsp(0, 32'h40000000);
    set_req(0, 32'h3f800000, 32'h40000000);
    @(negedge clk);
    check("single_req_ready", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    check("exec_req_ready", 32'(req_ready), 32'h0);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_drain(50);

    // All four at once from a reset pointer: grants 0,1,2,3.
    do_reset();
    expect_rsp(0, 32'h40c80000);
    expect_rsp(1, 32'h419d8000);
    expect_rsp(2, 32'hc05c0000);
    expect_rsp(3, 32'h40000000);
    set_req(0, 32'h40200000, 32'h40200000);
    set_req(1, 32'h40a80000, 32'h40700000);
    set_req(2, 32'hc0300000, 32'h3fa00000);
    set_req(3, 32'h3f800000, 32'h40000000);
    wait_drain(100);

    // Backpressure: response held, no new grant until the handshake.
    rsp_ready = 1'b0;
    expect_rsp(1, 32'h40c00000);
    expect_rsp(2, 32'h3f800000);
    set_req(1, 32'h40400000, 32'h40000000);
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      if (!seen) fail_now("bp_rsp_valid_wait");
    end
    tick();
    set_req(2, 32'h3f800000, 32'h3f800000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", rsp_result, 32'h40c00000);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    tick();
    rsp_ready = 1'b1;
    wait_drain(50);

    // Pointer at 3: grant req2, then req3 must precede req1.
    expect_rsp(2, 32'h40800000);
    expect_rsp(3, 32'hc0000000);
    expect_rsp(1, 32'h41100000);
    set_req(2, 32'h40000000, 32'h40000000);
    wait_drop(2);
    set_req(1, 32'h40400000, 32'h40400000);
    set_req(3, 32'h3f800000, 32'hc0000000);
    wait_drain(100);

    // Reset while in EXEC: the operation vanishes and the pointer returns to 0.
    set_req(0, 32'h3f800000, 32'h40000000);
    wait_drop(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    expect_rsp(0, 32'h40c00000);
    expect_rsp(1, 32'h40000000);
    set_req(0, 32'h40000000, 32'h40400000);
    set_req(1, 32'h3f000000, 32'h40800000);
    wait_drain(100);

    // Special operands and the handshake counter.
    do_reset();
    expect_rsp(0, 32'h7fc00000);
    expect_rsp(1, 32'hff800000);
    set_req(0, 32'h7f800000, 32'h00000000);
    wait_drop(0);
    set_req(1, 32'hff800000, 32'h3f800000);
    wait_drain(100);
    @(negedge clk);
`ifdef FP_MUL_ARB_STATS_EN
    check("op_count", op_count, 32'd2);
`else
    check("op_count", op_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
